// File: rtl/register_bank_sb.sv
// register_bank_sb
//   Register bank for the pipelined RISC-V core. It has two combinational read
//   ports, one synchronous write port, an optional write-to-read bypass and
//   one scoreboard pending bit per register. After reset, the array is cleared
//   one register per cycle. The array itself has no reset.
//
// Ports
//   clk                   rising-edge clock
//   rst_n                 asynchronous active-low reset
//   init_busy             high during reset and while the clear sequence runs
//   read_register_1_addr  read port 1 address
//   read_register_2_addr  read port 2 address
//   read_data_1/2         read port data (zero while init_busy)
//   read_pending_1/2      pending bit of the addressed register (zero while init_busy)
//   write_enable          writeback strobe
//   write_register_addr   writeback address
//   write_data            writeback data
//   issue_enable          marks issue_addr pending
//   issue_addr            destination register of the issuing instruction
//   flush                 clears all pending bits
//   pending_count         registered number of pending bits
module register_bank_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  input  logic [ADDR_WIDTH-1:0] read_register_1_addr,
  input  logic [ADDR_WIDTH-1:0] read_register_2_addr,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic                  read_pending_1,
  output logic                  read_pending_2,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_register_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  issue_enable,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   pending_count
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int unsigned CW       = ADDR_WIDTH + 1;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  busy_q;
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_nxt;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;
  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  logic                  ready;
  logic                  wr_ok;
  logic                  iss_ok;
  logic [ADDR_WIDTH-1:0] raddr [2];
  logic [DATA_WIDTH-1:0] rdata [2];
  logic                  rpend [2];

  assign ready = (state == READY);

  // Register 0 accepts neither writes nor issues when it is hardwired.
  assign wr_ok  = ready && write_enable &&
                  !((ZERO_REG != 0) && (write_register_addr == '0));
  assign iss_ok = ready && issue_enable &&
                  !((ZERO_REG != 0) && (issue_addr == '0));

  // Init FSM, pending bits and count. The pending state only moves in READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_ptr <= '0;
      busy_q  <= 1'b1;
      pending <= '0;
      count_q <= '0;
    end else begin
      case (state)
        INIT: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == '1) begin
            state  <= READY;
            busy_q <= 1'b0;
          end
        end
        READY: begin
          pending <= pending_nxt;
          count_q <= count_nxt;
        end
        default: begin
          state   <= INIT;
          clr_ptr <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Storage array (no reset). It is cleared by the init sequence.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_ptr] <= '0;
    end else if (wr_ok) begin
      mem[write_register_addr] <= write_data;
    end
  end

  // The pending update is applied in rising priority: writeback clear,
  // then issue set, then flush. The last assignment wins.
  always_comb begin
    pending_nxt = pending;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (write_enable && (write_register_addr == ADDR_WIDTH'(i)))
        pending_nxt[i] = 1'b0;
      if (iss_ok && (issue_addr == ADDR_WIDTH'(i)))
        pending_nxt[i] = 1'b1;
    end
    if (flush)
      pending_nxt = '0;
  end

  always_comb begin
    count_nxt = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      count_nxt = count_nxt + CW'(pending_nxt[i]);
  end

  assign raddr[0] = read_register_1_addr;
  assign raddr[1] = read_register_2_addr;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rdata[p] = '0;
      rpend[p] = 1'b0;
      if (ready) begin
        if ((ZERO_REG != 0) && (raddr[p] == '0))
          rdata[p] = '0;
        else if ((BYPASS != 0) && wr_ok && (write_register_addr == raddr[p]))
          rdata[p] = write_data;
        else
          rdata[p] = mem[raddr[p]];

        // With bypass, hide a pending bit that this cycle's writeback clears.
        // A same-cycle issue to the address keeps it pending.
        rpend[p] = pending[raddr[p]];
        if ((BYPASS != 0) && write_enable && (write_register_addr == raddr[p]) &&
            !(issue_enable && (issue_addr == raddr[p])))
          rpend[p] = 1'b0;
      end
    end
  end

  assign read_data_1    = rdata[0];
  assign read_data_2    = rdata[1];
  assign read_pending_1 = rpend[0];
  assign read_pending_2 = rpend[1];
  assign init_busy      = busy_q;
  assign pending_count  = count_q;

endmodule
